// File: rtl/hsynq_monitor.sv
// hsynq_monitor: receive-side checker for VGA hsynq/display line timing.
// Measures each line segment, tracks lock and reports coded timing errors.
`timescale 1ns/1ps
module hsynq_monitor #(
    parameter int SYNC_CLKS      = 192,
    parameter int BP_CLKS        = 96,
    parameter int DISP_CLKS      = 1280,
    parameter int FP_CLKS        = 32,
    parameter int CLKS_PER_PIXEL = 2,
    parameter int LOCK_LINES     = 2,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsynq,
    input  logic        display,
    output logic        locked,
    output logic        line_done,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [15:0] line_count
);

    typedef enum logic [2:0] {
        HUNT,
        SYNC,
        BP,
        ACTIVE,
        FP
    } state_t;

    localparam int STK_W = $clog2(LOCK_LINES + 1);
    localparam int DIV_W =
        (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

    localparam logic [CNT_W-1:0] SYNC_N = CNT_W'(SYNC_CLKS);
    localparam logic [CNT_W-1:0] BP_N   = CNT_W'(BP_CLKS);
    localparam logic [CNT_W-1:0] DISP_N = CNT_W'(DISP_CLKS);
    localparam logic [CNT_W-1:0] FP_N   = CNT_W'(FP_CLKS);
    localparam logic [9:0] PX_LAST =
        10'(DISP_CLKS / CLKS_PER_PIXEL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(CLKS_PER_PIXEL - 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(LOCK_LINES);

    logic             hs_q, hs_qq;
    logic             de_q, de_qq;
    state_t           st, nxt;
    logic [CNT_W-1:0] seg_cnt;
    logic [DIV_W-1:0] pix_div;
    logic [STK_W-1:0] streak, streak_nxt;
    logic             hs_fall, hs_rise;
    logic             de_rise, de_fall;
    logic             err, good;
    logic [2:0]       code;

    assign hs_fall = hs_qq & ~hs_q;
    assign hs_rise = ~hs_qq & hs_q;
    assign de_rise = ~de_qq & de_q;
    assign de_fall = de_qq & ~de_q;

    assign streak_nxt =
        (streak == STK_MAX) ? streak : streak + 1'b1;

    always_comb begin
        nxt  = st;
        err  = 1'b0;
        code = 3'd0;
        good = 1'b0;
        unique case (st)
            HUNT: begin
                if (hs_fall) nxt = SYNC;
            end
            SYNC: begin
                if (de_q)
                    {err, code} = {1'b1, 3'd5};
                else if (hs_rise) begin
                    if (seg_cnt == SYNC_N) nxt = BP;
                    else {err, code} = {1'b1, 3'd1};
                end else if (seg_cnt > SYNC_N)
                    {err, code} = {1'b1, 3'd1};
            end
            BP: begin
                if (hs_fall || (de_q && !de_rise))
                    {err, code} = {1'b1, 3'd5};
                else if (de_rise) begin
                    if (seg_cnt == BP_N) nxt = ACTIVE;
                    else {err, code} = {1'b1, 3'd2};
                end else if (seg_cnt > BP_N)
                    {err, code} = {1'b1, 3'd2};
            end
            ACTIVE: begin
                if (hs_fall)
                    {err, code} = {1'b1, 3'd5};
                else if (de_fall) begin
                    if (seg_cnt == DISP_N) nxt = FP;
                    else {err, code} = {1'b1, 3'd3};
                end else if (seg_cnt > DISP_N)
                    {err, code} = {1'b1, 3'd3};
            end
            FP: begin
                if (de_q)
                    {err, code} = {1'b1, 3'd5};
                else if (hs_fall) begin
                    if (seg_cnt == FP_N) begin
                        nxt  = SYNC;
                        good = 1'b1;
                    end else {err, code} = {1'b1, 3'd4};
                end else if (seg_cnt > FP_N)
                    {err, code} = {1'b1, 3'd4};
            end
            default: nxt = HUNT;
        endcase
        // an error on a sync fall restarts measurement at once
        if (err) nxt = hs_fall ? SYNC : HUNT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q        <= 1'b1;
            hs_qq       <= 1'b1;
            de_q        <= 1'b0;
            de_qq       <= 1'b0;
            st          <= HUNT;
            seg_cnt     <= '0;
            pix_div     <= '0;
            streak      <= '0;
            locked      <= 1'b0;
            line_done   <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            line_count  <= '0;
        end else begin
            hs_q  <= hsynq;
            hs_qq <= hs_q;
            de_q  <= display;
            de_qq <= de_q;
            st    <= nxt;

            if (nxt != st || err)
                seg_cnt <= CNT_W'(1);
            else if (st != HUNT)
                seg_cnt <= seg_cnt + 1'b1;

            line_done   <= good;
            err_valid   <= err;
            err_code    <= code;
            pixel_valid <= (nxt == ACTIVE);

            if (nxt == ACTIVE && st != ACTIVE) begin
                pixel_x <= '0;
                pix_div <= '0;
            end else if (st == ACTIVE) begin
                if (pix_div == DIV_LAST) begin
                    pix_div <= '0;
                    if (pixel_x != PX_LAST)
                        pixel_x <= pixel_x + 1'b1;
                end else begin
                    pix_div <= pix_div + 1'b1;
                end
            end

            if (err) begin
                streak <= '0;
                locked <= 1'b0;
            end else if (good) begin
                streak <= streak_nxt;
                if (streak_nxt == STK_MAX)
                    locked <= 1'b1;
                if (line_count != 16'hFFFF)
                    line_count <= line_count + 1'b1;
            end
        end
    end

endmodule
